// File: rtl/stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall controller.
// FSM state encoding plus default watchdog and counter sizes.
package stall_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } stall_state_e;

    localparam int MEM_TIMEOUT_DEFAULT    = 255;
    localparam int PERF_CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/stall_perf_counters.sv
// Pair of free-running event counters with synchronous active-low clear.
// Only instantiated when STALL_PERF_CNT_EN is defined.
module stall_perf_counters #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc_stall,
    input  logic             i_inc_flush,
    output logic [WIDTH-1:0] o_stall_cnt,
    output logic [WIDTH-1:0] o_flush_cnt
);

    logic [WIDTH-1:0] r_stall_cnt;
    logic [WIDTH-1:0] r_flush_cnt;

    // Count enabled cycles; overflow wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= {WIDTH{1'b0}};
            r_flush_cnt <= {WIDTH{1'b0}};
        end else begin
            if (i_inc_stall) begin
                r_stall_cnt <= r_stall_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (i_inc_flush) begin
                r_flush_cnt <= r_flush_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Per-stage freeze/flush/bubble generation with memory-wait FSM and watchdog.
// Optional performance counters are built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller
    import stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEFAULT,
    parameter int PERF_CNT_WIDTH = PERF_CNT_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hazard_detected,
    input  logic                      branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_freeze,
    output logic                      if_id_freeze,
    output logic                      if_id_flush,
    output logic                      id_exe_bubble,
    output logic                      id_exe_flush,
    output logic                      back_freeze,
    output logic                      mem_wait_state,
    output logic                      mem_timeout,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
    output logic [PERF_CNT_WIDTH-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    // The counter reaches MEM_TIMEOUT on the same edge the error is raised
    localparam logic [WAIT_W-1:0] WAIT_ARM = WAIT_W'(MEM_TIMEOUT - 1);

    logic w_mem_stall;
    logic w_pc_freeze;
    logic w_if_id_freeze;
    logic w_if_id_flush;
    logic w_id_exe_bubble;
    logic w_id_exe_flush;
    logic w_back_freeze;

    stall_state_e      r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    assign w_mem_stall = mem_req & ~mem_ready;

    // Prioritised control decode: memory stall, then branch, then hazard
    always_comb begin
        w_pc_freeze     = 1'b0;
        w_if_id_freeze  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_exe_bubble = 1'b0;
        w_id_exe_flush  = 1'b0;
        w_back_freeze   = 1'b0;
        if (!rst_n) begin
            w_pc_freeze = 1'b0;
        end else if (w_mem_stall) begin
            w_pc_freeze    = 1'b1;
            w_if_id_freeze = 1'b1;
            w_back_freeze  = 1'b1;
        end else if (branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_exe_flush = 1'b1;
        end else if (hazard_detected) begin
            w_pc_freeze     = 1'b1;
            w_if_id_freeze  = 1'b1;
            w_id_exe_bubble = 1'b1;
        end else begin
            w_pc_freeze = 1'b0;
        end
    end

    // Memory-wait FSM with saturating watchdog and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= {WAIT_W{1'b0}};
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= {WAIT_W{1'b0}};
                    if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                    end else begin
                        r_state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                        if (r_wait_cnt != WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
                        end else begin
                            r_wait_cnt <= r_wait_cnt;
                        end
                        if (r_wait_cnt >= WAIT_ARM) begin
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_mem_timeout <= r_mem_timeout;
                        end
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    assign pc_freeze      = w_pc_freeze;
    assign if_id_freeze   = w_if_id_freeze;
    assign if_id_flush    = w_if_id_flush;
    assign id_exe_bubble  = w_id_exe_bubble;
    assign id_exe_flush   = w_id_exe_flush;
    assign back_freeze    = w_back_freeze;
    assign mem_wait_state = (r_state == MEM_WAIT);
    assign mem_timeout    = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
    stall_perf_counters #(
        .WIDTH(PERF_CNT_WIDTH)
    ) u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc_stall (w_pc_freeze),
        .i_inc_flush (w_if_id_flush),
        .o_stall_cnt (stall_cycles),
        .o_flush_cnt (flush_count)
    );
`else
    assign stall_cycles = {PERF_CNT_WIDTH{1'b0}};
    assign flush_count  = {PERF_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=4).
// Table of combinational vectors plus hand sequences for wait, timeout and counters.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n, hazard_detected, branch_taken, mem_req, mem_ready;
    logic        pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, id_exe_flush, back_freeze;
    logic        mem_wait_state, mem_timeout;
    logic [31:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_err    = 0;

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .PERF_CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_exe_bubble(id_exe_bubble), .id_exe_flush(id_exe_flush), .back_freeze(back_freeze),
        .mem_wait_state(mem_wait_state), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, id_exe_flush, back_freeze}
    typedef struct {
        string      name;
        logic       rn, hz, br, rq, rd;
        logic [5:0] exp;
    } vec_t;

    function automatic logic [5:0] outs();
        return {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, id_exe_flush, back_freeze};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn, hz, br, rq, rd);
        rst_n = rn; hazard_detected = hz; branch_taken = br; mem_req = rq; mem_ready = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[8];
    logic [31:0] exp_stall, exp_flush;

    initial begin
        vecs[0] = '{"rst_forces_zero", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000};
        vecs[1] = '{"hazard",          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};
        vecs[2] = '{"idle",            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[3] = '{"branch_over_hz",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001010};
        vecs[4] = '{"req_rdy_hazard",  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b110100};
        vecs[5] = '{"memstall_wins",   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b110001};
        vecs[6] = '{"req_rdy_branch",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b001010};
        vecs[7] = '{"idle_end",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        // Reset held two cycles with hostile inputs
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_wait_state", 32'(mem_wait_state), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_flush_count", flush_count, 32'd0);

        // Hazard for one cycle, then released
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("hz_one_cycle", 32'(outs()), 32'h34);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("hz_released", 32'(outs()), 32'd0);

        // Combinational vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].rn, vecs[i].hz, vecs[i].br, vecs[i].rq, vecs[i].rd);
            #1 chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Memory wait with branch pending: ready arrives in cycle 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) drive(1'b1, 1'b0, 1'b1, 1'b1, (k == 3));
            else       drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("mw_back_freeze_c%0d", k), 32'(back_freeze), 32'(k < 3));
            chk($sformatf("mw_if_id_flush_c%0d", k), 32'(if_id_flush), 32'(k == 3));
            chk($sformatf("mw_state_c%0d", k), 32'(mem_wait_state), 32'(k >= 1 && k <= 3));
        end

        // Watchdog: stall starts cycle 0, error from edge 5, sticky past ready
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("to_edge%0d", k), 32'(mem_timeout), 32'(k >= 5));
        end
        chk("to_still_frozen", 32'(pc_freeze), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_state_after_ready", 32'(mem_wait_state), 32'd0);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        @(negedge clk);
        chk("to_sticky_idle", 32'(mem_timeout), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_cleared_by_rst", 32'(mem_timeout), 32'd0);

        // Reset mid-wait aborts to RUN on the next edge
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("abort_in_wait", 32'(mem_wait_state), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("abort_to_run", 32'(mem_wait_state), 32'd0);

        // Performance counters: 3 hazard cycles then 2 branch cycles
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STALL_PERF_CNT_EN
        exp_stall = 32'd3;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        #1;
        chk("perf_stall_cycles", stall_cycles, exp_stall);
        chk("perf_flush_count", flush_count, exp_flush);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
